// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: machine widths, reset PC default, FSM states and buffer entry.
package mips_pkg;
   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {pc, instruction} pairs between instruction memory and decode.
module ifetch_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage carries no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC generation, credit-limited in-order memory reads, redirect flush, decode handoff.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic               imem_req_out,
   output logic [XLEN-1:0]    imem_addr_out,
   input  logic               imem_ack_in,
   input  logic               imem_rvalid_in,
   input  logic [INSTR_W-1:0] imem_rdata_in,
   input  logic               redirect_in,
   input  logic [XLEN-1:0]    redirect_pc_in,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [XLEN-1:0]    pc_out,
   output logic [XLEN-1:0]    pc_plus4_out,
   output logic               valid_out,
   input  logic               ready_in
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW:0]   CREDITS = (CW+1)'(BUF_DEPTH);
   localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);

   fetch_state_t  state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] discard;
   logic [CW-1:0] discard_next;
   logic [CW-1:0] count;
   logic [CW:0]   credit_used;
   logic          fifo_valid;
   logic          transfer;
   logic          drop;
   logic          push;
   logic          pop;
   fetch_entry_t  push_data;
   fetch_entry_t  head;
   logic          redirect_lsb_unused;

   assign redirect_lsb_unused = ^redirect_pc_in[1:0];
   assign target_pc = {redirect_pc_in[XLEN-1:2], 2'b00};

   assign fifo_valid = (count != '0);
   assign pop        = fifo_valid & ready_in & ~redirect_in;

   // The slot freed by this cycle's pop is re-lent immediately, which is what
   // sustains one fetch per cycle with a two-entry buffer and 1-cycle memory.
   assign credit_used  = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
   assign imem_req_out = (state == ST_FETCH) & (credit_used < CREDITS) & ~redirect_in;
   assign imem_addr_out = fetch_pc;
   assign transfer      = imem_req_out & imem_ack_in;

   assign drop = imem_rvalid_in & (redirect_in | (discard != '0));
   assign push = imem_rvalid_in & ~drop;
   assign push_data = '{pc: resp_pc, instr: imem_rdata_in};

   always_comb begin
      discard_next = discard;
      if (redirect_in && state != ST_FLUSH) begin
         discard_next = inflight - CW'(imem_rvalid_in);
      end else if (imem_rvalid_in && discard != '0) begin
         discard_next = discard - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else begin
         inflight <= inflight + CW'(transfer) - CW'(imem_rvalid_in);
         discard  <= discard_next;

         if (redirect_in) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
         end else begin
            if (transfer) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
            end
         end

         case (state)
            ST_IDLE:  state <= ST_FETCH;
            ST_FETCH: if (redirect_in && discard_next != '0) state <= ST_FLUSH;
            ST_FLUSH: if (discard_next == '0) state <= ST_FETCH;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   ifetch_fifo #(
      .DEPTH(BUF_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (redirect_in),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   // Invalid slots read as zero so decode never sees stale or unreset storage.
   assign valid_out       = fifo_valid;
   assign instruction_out = fifo_valid ? head.instr : '0;
   assign pc_out          = fifo_valid ? head.pc : '0;
   assign pc_plus4_out    = fifo_valid ? (head.pc + 32'd4) : '0;

   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (!(push && !pop && count == FULL));
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, backpressure, redirects, wrap and reset-in-flush.
module tb_instr_fetch;
   logic        clock;
   logic        reset_n;
   logic        imem_req_out;
   logic [31:0] imem_addr_out;
   logic        imem_ack_in;
   logic        imem_rvalid_in;
   logic [31:0] imem_rdata_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic        valid_out;
   logic        ready_in;

   logic        hold;
   logic [31:0] mq[$];
   int          checks;
   int          errors;

   instr_fetch #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .imem_req_out    (imem_req_out),
      .imem_addr_out   (imem_addr_out),
      .imem_ack_in     (imem_ack_in),
      .imem_rvalid_in  (imem_rvalid_in),
      .imem_rdata_in   (imem_rdata_in),
      .redirect_in     (redirect_in),
      .redirect_pc_in  (redirect_pc_in),
      .instruction_out (instruction_out),
      .pc_out          (pc_out),
      .pc_plus4_out    (pc_plus4_out),
      .valid_out       (valid_out),
      .ready_in        (ready_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: answers each accepted request one cycle later with data = address,
   // queueing requests while hold is set.
   always @(posedge clock) begin
      if (!reset_n) begin
         mq.delete();
         imem_rvalid_in <= 1'b0;
         imem_rdata_in  <= '0;
      end else begin
         if (!hold && mq.size() > 0) begin
            imem_rvalid_in <= 1'b1;
            imem_rdata_in  <= mq.pop_front();
            if (imem_req_out && imem_ack_in) mq.push_back(imem_addr_out);
         end else if (!hold && imem_req_out && imem_ack_in) begin
            imem_rvalid_in <= 1'b1;
            imem_rdata_in  <= imem_addr_out;
         end else begin
            imem_rvalid_in <= 1'b0;
            if (imem_req_out && imem_ack_in) mq.push_back(imem_addr_out);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic expect_stream(input string tag, input logic [31:0] start, input int n,
                                input int budget);
      logic [31:0] exp;
      int got;
      exp = start;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         if (valid_out && ready_in) begin
            check({tag, "_pc"}, pc_out, exp);
            check({tag, "_instr"}, instruction_out, exp);
            check({tag, "_pc4"}, pc_plus4_out, exp + 32'd4);
            exp = exp + 32'd4;
            got++;
         end
         step();
      end
      if (got != n) check({tag, "_timeout"}, 32'(got), 32'(n));
   endtask

   task automatic wait_req(input string tag, input int budget);
      for (int c = 0; c < budget && !imem_req_out; c++) step();
      check({tag, "_req"}, 32'(imem_req_out), 32'd1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_req"}, 32'(imem_req_out), 32'd0);
      check({tag, "_valid"}, 32'(valid_out), 32'd0);
      check({tag, "_instr"}, instruction_out, 32'd0);
      check({tag, "_pc"}, pc_out, 32'd0);
      check({tag, "_pc4"}, pc_plus4_out, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      imem_ack_in = 1'b1;
      redirect_in = 1'b0;
      redirect_pc_in = '0;
      ready_in = 1'b0;
      hold = 1'b0;

      // Reset held three cycles, then one idle cycle, then first fetch at RESET_PC.
      @(negedge clock);
      step(); step(); step();
      check_zero_outputs("rst");
      reset_n = 1'b1;
      #1;
      check("idle_req", 32'(imem_req_out), 32'd0);
      step();
      check("first_req", 32'(imem_req_out), 32'd1);
      check("first_addr", imem_addr_out, 32'h0000_0000);
      ready_in = 1'b1;

      // Back-to-back stream with 1-cycle memory.
      for (int c = 0; c < 10 && !valid_out; c++) step();
      for (int i = 0; i < 4; i++) begin
         check("b2b_valid", 32'(valid_out), 32'd1);
         check("b2b_pc", pc_out, 32'(4 * i));
         check("b2b_instr", instruction_out, 32'(4 * i));
         check("b2b_pc4", pc_plus4_out, 32'(4 * i + 4));
         step();
      end

      // Decode stalls: buffer fills, requests stop, head holds.
      ready_in = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         check("stall_req", 32'(imem_req_out), 32'd0);
         check("stall_valid", 32'(valid_out), 32'd1);
         check("stall_pc", pc_out, 32'h10);
         step();
      end
      ready_in = 1'b1;
      expect_stream("resume", 32'h10, 6, 30);

      // Two fetches outstanding, then redirect to an unaligned target.
      hold = 1'b1;
      step(); step(); step(); step();
      check("hold_req", 32'(imem_req_out), 32'd0);
      check("hold_valid", 32'(valid_out), 32'd0);
      redirect_in = 1'b1;
      redirect_pc_in = 32'h0000_0402;
      #1;
      check("redir_req", 32'(imem_req_out), 32'd0);
      step();
      redirect_in = 1'b0;
      hold = 1'b0;
      #1;
      check("flush_valid", 32'(valid_out), 32'd0);
      check("flush_req", 32'(imem_req_out), 32'd0);
      wait_req("redir", 10);
      check("redir_addr", imem_addr_out, 32'h0000_0400);
      expect_stream("redir", 32'h400, 3, 20);

      // Redirect colliding with a response and a pop; nothing stale, so no flush.
      check("coll_pre_valid", 32'(valid_out), 32'd1);
      redirect_in = 1'b1;
      redirect_pc_in = 32'h0000_0800;
      #1;
      check("coll_req", 32'(imem_req_out), 32'd0);
      step();
      redirect_in = 1'b0;
      #1;
      check("coll_valid", 32'(valid_out), 32'd0);
      check("coll_req_next", 32'(imem_req_out), 32'd1);
      check("coll_addr", imem_addr_out, 32'h0000_0800);
      expect_stream("coll", 32'h800, 3, 20);

      // Redirect to the top word: address space wraps to zero.
      redirect_in = 1'b1;
      redirect_pc_in = 32'hFFFF_FFFF;
      step();
      redirect_in = 1'b0;
      #1;
      check("wrap_addr", imem_addr_out, 32'hFFFF_FFFC);
      expect_stream("wrap", 32'hFFFF_FFFC, 3, 20);

      // Reset while flushing stale fetches restarts cleanly.
      hold = 1'b1;
      step(); step(); step(); step();
      check("flrst_hold_req", 32'(imem_req_out), 32'd0);
      redirect_in = 1'b1;
      redirect_pc_in = 32'h0000_1000;
      step();
      redirect_in = 1'b0;
      step();
      check("flrst_flush_req", 32'(imem_req_out), 32'd0);
      reset_n = 1'b0;
      hold = 1'b0;
      step(); step();
      check_zero_outputs("flrst");
      reset_n = 1'b1;
      #1;
      check("flrst_idle_req", 32'(imem_req_out), 32'd0);
      step();
      check("flrst_req", 32'(imem_req_out), 32'd1);
      check("flrst_addr", imem_addr_out, 32'h0000_0000);
      expect_stream("flrst", 32'h0, 4, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
